// File: rtl/countdown_sequencer.sv
// countdown_sequencer: programmable countdown timer controller.
// Loads a start value, decrements it once every DIV clocks, and supports
// pause/resume, abort and optional auto-reload. Expiry is flagged by a
// one-cycle done pulse that is decoded from the EXPIRE state.
module countdown_sequencer #(
  parameter int WIDTH = 4,
  parameter int DIV   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] load_val,
  input  logic             auto_reload,
  input  logic             pause,
  input  logic             abort,
  output logic [WIDTH-1:0] q,
  output logic             done,
  output logic             busy,
  output logic [1:0]       state
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RUN    = 2'b01,
    HOLD   = 2'b10,
    EXPIRE = 2'b11
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic             countStep;
  logic             lastPresc;

  assign lastPresc = (presc_q == PRESC_LAST);

  // State and datapath registers; reset clears everything at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      presc_q  <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      presc_q  <= presc_d;
    end
  end

  // Next-state and datapath control. Abort beats pause, pause beats a tick.
  // Leaving HOLD counts in the same cycle it resumes, so a pause held for
  // P cycles delays expiry by exactly P cycles.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    reload_d  = reload_q;
    presc_d   = presc_q;
    countStep = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          count_d  = load_val;
          reload_d = load_val;
          presc_d  = '0;
          state_d  = (load_val == '0) ? EXPIRE : RUN;
        end
      end

      RUN: begin
        if (abort) begin
          state_d = IDLE;
          count_d = '0;
          presc_d = '0;
        end else if (pause) begin
          state_d = HOLD;
        end else begin
          countStep = 1'b1;
        end
      end

      HOLD: begin
        if (abort) begin
          state_d = IDLE;
          count_d = '0;
          presc_d = '0;
        end else if (!pause) begin
          state_d   = RUN;
          countStep = 1'b1;
        end
      end

      EXPIRE: begin
        if (abort) begin
          state_d = IDLE;
        end else if (auto_reload && (reload_q != '0)) begin
          state_d = RUN;
          count_d = reload_q;
          presc_d = '0;
        end else begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (countStep) begin
      if (lastPresc) begin
        presc_d = '0;
        if (count_q <= WIDTH'(1)) begin
          count_d = '0;
          state_d = EXPIRE;
        end else begin
          count_d = count_q - WIDTH'(1);
        end
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end
  end

  assign q     = count_q;
  assign state = state_q;
  assign done  = (state_q == EXPIRE);
  assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_countdown_sequencer.sv
// tb_countdown_sequencer: directed checks of the countdown timer with
// DIV=2 and DIV=4 instances sharing one set of stimulus inputs.
module tb_countdown_sequencer;

  localparam int WIDTH = 4;

  logic             clk;
  logic             reset;
  logic             start;
  logic [WIDTH-1:0] load_val;
  logic             auto_reload;
  logic             pause;
  logic             abort;

  logic [WIDTH-1:0] q2, q4;
  logic             done2, done4;
  logic             busy2, busy4;
  logic [1:0]       state2, state4;

  int checkCount;
  int passCount;

  countdown_sequencer #(.WIDTH(WIDTH), .DIV(2)) dut2 (
    .clk(clk), .reset(reset), .start(start), .load_val(load_val),
    .auto_reload(auto_reload), .pause(pause), .abort(abort),
    .q(q2), .done(done2), .busy(busy2), .state(state2)
  );

  countdown_sequencer #(.WIDTH(WIDTH), .DIV(4)) dut4 (
    .clk(clk), .reset(reset), .start(start), .load_val(load_val),
    .auto_reload(auto_reload), .pause(pause), .abort(abort),
    .q(q4), .done(done4), .busy(busy4), .state(state4)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Drive the control inputs for the next sampling edge.
  task automatic applyStimulus(input logic st, input logic [WIDTH-1:0] lv,
                               input logic ar, input logic pa, input logic ab);
    start       = st;
    load_val    = lv;
    auto_reload = ar;
    pause       = pa;
    abort       = ab;
  endtask

  task automatic applyReset();
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    checkCount = 0;
    passCount  = 0;
    reset      = 1'b0;
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
    #2;

    // Basic countdown, DIV=2, N=3, with a start pulse ignored mid-count.
    applyReset();
    checkOutput("rst_q", 32'(q2), 0);
    checkOutput("rst_state", 32'(state2), 0);
    checkOutput("rst_busy", 32'(busy2), 0);
    checkOutput("rst_done", 32'(done2), 0);
    applyStimulus(1'b1, 4'd3, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 4'd3, 1'b0, 1'b0, 1'b0);
    checkOutput("e0_q", 32'(q2), 3);
    checkOutput("e0_state", 32'(state2), 1);
    checkOutput("e0_busy", 32'(busy2), 1);
    ticks(2);
    checkOutput("e2_q", 32'(q2), 2);
    tick();
    applyStimulus(1'b1, 4'd7, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 4'd7, 1'b0, 1'b0, 1'b0);
    checkOutput("e4_q_start_ignored", 32'(q2), 1);
    ticks(2);
    checkOutput("e6_q", 32'(q2), 0);
    checkOutput("e6_done", 32'(done2), 1);
    checkOutput("e6_state", 32'(state2), 3);
    tick();
    checkOutput("e7_state", 32'(state2), 0);
    checkOutput("e7_busy", 32'(busy2), 0);
    checkOutput("e7_done", 32'(done2), 0);

    // Auto-reload, DIV=2, N=2: done after edges 4, 9, 14.
    applyReset();
    applyStimulus(1'b1, 4'd2, 1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 4'd9, 1'b1, 1'b0, 1'b0);
    for (int e = 1; e <= 14; e++) begin
      tick();
      checkOutput($sformatf("ar_done_e%0d", e), 32'(done2),
                  (e == 4 || e == 9 || e == 14) ? 32'd1 : 32'd0);
      if (e == 5 || e == 10) checkOutput($sformatf("ar_q_e%0d", e), 32'(q2), 2);
    end

    // Pause, DIV=4, N=5: pause sampled at edges 7..13, done moves 20 -> 27.
    applyReset();
    applyStimulus(1'b1, 4'd5, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    ticks(6);
    checkOutput("p_e6_q", 32'(q4), 4);
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    for (int e = 7; e <= 13; e++) begin
      tick();
      checkOutput($sformatf("p_hold_state_e%0d", e), 32'(state4), 2);
      checkOutput($sformatf("p_hold_q_e%0d", e), 32'(q4), 4);
    end
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("p_e14_state", 32'(state4), 1);
    checkOutput("p_e14_q", 32'(q4), 4);
    tick();
    checkOutput("p_e15_q", 32'(q4), 3);
    ticks(5);
    checkOutput("p_e20_done", 32'(done4), 0);
    ticks(6);
    checkOutput("p_e26_done", 32'(done4), 0);
    tick();
    checkOutput("p_e27_done", 32'(done4), 1);
    checkOutput("p_e27_q", 32'(q4), 0);

    // Abort in RUN, DIV=2, N=9 at q=6, then restart with N=1.
    applyReset();
    applyStimulus(1'b1, 4'd9, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    ticks(6);
    checkOutput("ab_e6_q", 32'(q2), 6);
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("ab_state", 32'(state2), 0);
    checkOutput("ab_q", 32'(q2), 0);
    checkOutput("ab_done", 32'(done2), 0);
    tick();
    checkOutput("ab_done_after", 32'(done2), 0);
    applyStimulus(1'b1, 4'd1, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("ab_re_e0_q", 32'(q2), 1);
    tick();
    checkOutput("ab_re_e1_done", 32'(done2), 0);
    tick();
    checkOutput("ab_re_e2_done", 32'(done2), 1);

    // Zero load value goes straight to EXPIRE, with and without auto-reload.
    applyReset();
    applyStimulus(1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("z_state", 32'(state2), 3);
    checkOutput("z_done", 32'(done2), 1);
    tick();
    checkOutput("z_idle", 32'(state2), 0);
    checkOutput("z_done_off", 32'(done2), 0);
    applyStimulus(1'b1, 4'd0, 1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    checkOutput("zar_done", 32'(done2), 1);
    tick();
    checkOutput("zar_idle", 32'(state2), 0);
    checkOutput("zar_busy", 32'(busy2), 0);

    // Asynchronous reset between edges while counting at q=3.
    applyReset();
    applyStimulus(1'b1, 4'd5, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    ticks(4);
    checkOutput("ar_pre_q", 32'(q2), 3);
    #3 reset = 1'b1;
    #1;
    checkOutput("async_q", 32'(q2), 0);
    checkOutput("async_state", 32'(state2), 0);
    checkOutput("async_busy", 32'(busy2), 0);
    checkOutput("async_done", 32'(done2), 0);
    #2 reset = 1'b0;
    tick();
    checkOutput("async_hold_idle", 32'(state2), 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/countdown_sequencer.md
Name: countdown_sequencer

Overview:
Controller that sequences a WIDTH-bit down-counter datapath as a programmable countdown timer. It loads a start value on a start pulse and decrements it once every DIV clocks. It supports pause/resume, abort and optional auto-reload. It signals expiry with a single-cycle done pulse. It sits between a requesting control block (start/abort/pause) and any logic consuming q/done.

Parameters:
WIDTH, 4, bit width of count value q and load_val
DIV, 4, clocks per decrement tick (prescaler period), legal range 1..256

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  request to load load_val and begin counting; honoured only in IDLE
load_val  input  WIDTH  start value, sampled on the cycle start is accepted
auto_reload  input  1  sampled in EXPIRE; 1 = restart from latched reload value
pause  input  1  level; 1 freezes counting (RUN->HOLD), 0 resumes
abort  input  1  pulse/level; returns to IDLE from any non-IDLE state, no done
q  output  WIDTH  current count value (registered)
done  output  1  high for exactly one cycle per expiry (registered)
busy  output  1  high whenever state != IDLE
state  output  2  FSM state: 00 IDLE, 01 RUN, 10 HOLD, 11 EXPIRE

Behaviour:
- Reset (async, any time, incl. mid-count): state=IDLE, q=0, done=0, busy=0, prescaler=0, reload register=0. Outputs take reset values immediately, without waiting for a clock edge.
- Internal regs: prescaler (ceil(log2(DIV)) bits, min 1), reload (WIDTH). Every output is a register or a decode of the state register. No combinational input-to-output paths.
- Priority in any non-IDLE state: abort > pause > tick.
- IDLE:
  - start=1 latches load_val into q and reload, clears prescaler, and moves to RUN.
  - If load_val==0, start moves directly to EXPIRE instead.
  - start=0: hold, q unchanged.
- RUN:
  - abort -> IDLE, q<=0, prescaler<=0.
  - Otherwise pause=1 -> HOLD. Prescaler and q are frozen, and no tick occurs in that cycle.
  - Otherwise prescaler increments. When prescaler==DIV-1: prescaler<=0 and q<=q-1 (tick).
  - A tick with q==1 sets q<=0 and moves to EXPIRE.
  - DIV=1: tick every RUN cycle.
- HOLD:
  - abort -> IDLE, q<=0.
  - pause=0 -> RUN; prescaler resumes from its frozen value.
  - Otherwise stay in HOLD; q and prescaler unchanged.
- EXPIRE:
  - Lasts exactly one cycle; done=1 while in EXPIRE, else 0.
  - abort -> IDLE, done still seen for this cycle.
  - Otherwise, auto_reload=1 and reload!=0: q<=reload, prescaler<=0, move to RUN.
  - Otherwise (auto_reload=0, or reload==0): move to IDLE, q stays 0.
- start is ignored outside IDLE. load_val is not re-sampled on auto-reload; the latched reload value is used.
- Timing (no pause): start sampled at edge 0 -> q=N, RUN after edge 0. q decrements at edges DIV, 2·DIV, …; q=0 and done=1 after edge N·DIV. Start-to-done latency = N·DIV cycles. With auto-reload, period = N·DIV+1 cycles.
- q never wraps. Decrement is only performed when q>=1, and reaching 0 always exits RUN.
- Simultaneous start+abort in IDLE: start wins, because abort has no effect in IDLE.

Test Plan:
- DIV=2, reset then start with load_val=3 -> q=3 after edge 0, 2 at edge 2, 1 at edge 4, 0 with done=1 and state=11 after edge 6. IDLE with busy=0 after edge 7.
- DIV=2, load_val=2, auto_reload=1 -> done pulses after edges 4, 9, 14 (period 5). q reloads to 2 the cycle after each done.
- DIV=4, load_val=5; assert pause for 7 cycles after edge 6 -> state=10, q=4 and prescaler frozen. Done is delayed by exactly 7 cycles (edge 27 instead of 20).
- DIV=2, load_val=9; abort in RUN at q=6 -> IDLE next edge, q=0, no done pulse. A subsequent start with load_val=1 -> done after edge 2.
- load_val=0 with start -> EXPIRE after edge 0, done=1 for one cycle, then IDLE. With auto_reload=1, still IDLE.
- Assert reset asynchronously mid-count (q=3, DIV=2) between clock edges -> q=0, state=00, busy=0, done=0 immediately. start pulses while busy are ignored (q sequence unchanged).
